pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor.
// Pulses the PLL reset, waits for lock (with a timeout and unlimited retries),
// qualifies lock for a programmable number of stable cycles, and then releases
// the downstream reset. While running, a filtered loss of lock restarts the
// whole sequence and is counted in a saturating relock counter.
`timescale 1ns/1ps

module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_FILTER   = 4
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       locked,
    output logic [7:0] relock_cnt,
    output logic       timeout_err
);

    // The phase counter is shared by the reset, wait and stable phases, so it
    // must hold the last value of the largest of the three limits.
    localparam int unsigned MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_RS > LOCK_TIMEOUT) ? MAX_RS : LOCK_TIMEOUT;
    localparam int          CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       LOSS_LAST    = 8'(LOSS_FILTER - 1);

    typedef enum logic [1:0] {
        S_PLLRST,
        S_WAIT,
        S_STABLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lossCnt_q, lossCnt_d;
    logic [7:0]       relockCnt_q, relockCnt_d;
    logic             pllReset_q, pllReset_d;
    logic             sysRst_q, sysRst_d;
    logic             locked_q, locked_d;
    logic             timeoutErr_q, timeoutErr_d;
    logic             sync1_q, lockS_q;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clkin.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            lockS_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            lockS_q <= sync1_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q      <= S_PLLRST;
            cnt_q        <= '0;
            lossCnt_q    <= '0;
            relockCnt_q  <= '0;
            pllReset_q   <= 1'b1;
            sysRst_q     <= 1'b1;
            locked_q     <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lossCnt_q    <= lossCnt_d;
            relockCnt_q  <= relockCnt_d;
            pllReset_q   <= pllReset_d;
            sysRst_q     <= sysRst_d;
            locked_q     <= locked_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they change
    // on the same edge as the transition that causes them.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lossCnt_d    = lossCnt_q;
        relockCnt_d  = relockCnt_q;
        timeoutErr_d = 1'b0;

        case (state_q)
            S_PLLRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (lockS_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d      = S_PLLRST;
                    cnt_d        = '0;
                    timeoutErr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!lockS_q) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    lossCnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (lockS_q) begin
                    lossCnt_d = '0;
                end else if (lossCnt_q == LOSS_LAST) begin
                    state_d   = S_PLLRST;
                    cnt_d     = '0;
                    lossCnt_d = '0;
                    if (relockCnt_q != 8'hFF) begin
                        relockCnt_d = relockCnt_q + 8'd1;
                    end
                end else begin
                    lossCnt_d = lossCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_PLLRST;
                cnt_d   = '0;
            end
        endcase

        pllReset_d = (state_d == S_PLLRST);
        sysRst_d   = (state_d != S_RUN);
        locked_d   = (state_d == S_RUN);
    end

    assign pll_reset   = pllReset_q;
    assign sys_rst     = sysRst_q;
    assign locked      = locked_q;
    assign relock_cnt  = relockCnt_q;
    assign timeout_err = timeoutErr_q;

endmodule
